// File: rtl/score_counter.sv
// score_counter
//   Runner-game score keeper. Counts displayed frames while a run is in
//   progress and converts every UNIT_DISTANCE counted frames into one BCD
//   score point, saturating at 99. Optionally tracks a high score.
//
//   Parameters
//     UNIT_DISTANCE  frame ticks per score point, 1..255 (default 30)
//
//   Ports
//     Clk          system clock, rising edge
//     Reset_n      asynchronous active-low reset
//     playing      1 while a run is in progress
//     frame_tick   one-cycle pulse per displayed frame
//     score_tens   BCD tens of current score
//     score_ones   BCD ones of current score
//     hi_tens      BCD tens of high score (0 when high score disabled)
//     hi_ones      BCD ones of high score (0 when high score disabled)
//     new_record   one-cycle pulse when the high score is replaced
//     state_o      FSM state for debug (IDLE=0, RUN=1, OVER=2)
//
//   Build option
//     SCORE_HISCORE_EN  define to build the high-score registers/comparator
//
//   state | meaning
//   IDLE  | after reset, waiting for the first run
//   RUN   | run in progress, frames are counted into the score
//   OVER  | run ended, score frozen until the next run starts
module score_counter #(
  parameter int UNIT_DISTANCE = 30
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       playing,
  input  logic       frame_tick,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic [3:0] hi_tens,
  output logic [3:0] hi_ones,
  output logic       new_record,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [7:0] SUB_LAST = 8'(UNIT_DISTANCE - 1);

  state_t     state;
  logic [7:0] sub_cnt;

  assign state_o = state;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      sub_cnt    <= 8'd0;
      score_tens <= 4'd0;
      score_ones <= 4'd0;
    end else begin
      case (state)
        IDLE, OVER: begin
          if (playing) begin
            state      <= RUN;
            sub_cnt    <= 8'd0;
            score_tens <= 4'd0;
            score_ones <= 4'd0;
          end
        end
        RUN: begin
          // A tick arriving in the same cycle playing drops is discarded.
          if (!playing) begin
            state <= OVER;
          end else if (frame_tick) begin
            if (sub_cnt == SUB_LAST) begin
              sub_cnt <= 8'd0;
              if (score_ones != 4'd9) begin
                score_ones <= score_ones + 4'd1;
              end else if (score_tens != 4'd9) begin
                score_ones <= 4'd0;
                score_tens <= score_tens + 4'd1;
              end
              // 99 holds: neither digit changes.
            end else begin
              sub_cnt <= sub_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCORE_HISCORE_EN
  // The RUN->OVER edge is the only place a score becomes final. Packed BCD
  // digits compare correctly as a plain 8-bit magnitude (tens above ones).
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hi_tens    <= 4'd0;
      hi_ones    <= 4'd0;
      new_record <= 1'b0;
    end else begin
      new_record <= 1'b0;
      if (state == RUN && !playing &&
          {score_tens, score_ones} > {hi_tens, hi_ones}) begin
        hi_tens    <= score_tens;
        hi_ones    <= score_ones;
        new_record <= 1'b1;
      end
    end
  end
`else
  assign hi_tens    = 4'd0;
  assign hi_ones    = 4'd0;
  assign new_record = 1'b0;
`endif

endmodule

// File: tb/tb_score_counter.sv
module tb_score_counter;

`ifdef SCORE_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif
  localparam int UD = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       playing = 1'b0;
  logic       frame_tick = 1'b0;
  logic [3:0] score_tens, score_ones, hi_tens, hi_ones;
  logic       new_record;
  logic [1:0] state_o;

  score_counter #(.UNIT_DISTANCE(UD)) dut (
    .Clk        (clk),
    .Reset_n    (rst_n),
    .playing    (playing),
    .frame_tick (frame_tick),
    .score_tens (score_tens),
    .score_ones (score_ones),
    .hi_tens    (hi_tens),
    .hi_ones    (hi_ones),
    .new_record (new_record),
    .state_o    (state_o)
  );

  always #10 clk = ~clk;

  logic [18:0] dut_vec;
  assign dut_vec = {state_o, score_tens, score_ones, hi_tens, hi_ones, new_record};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model of the score behaviour (integer score, not BCD digits).
  int m_state = 0;
  int m_sub = 0;
  int m_score = 0;
  int m_hi = 0;
  bit m_nr = 1'b0;
  logic [18:0] exp_q[$];

  function automatic logic [18:0] model_vec();
    return {2'(m_state), 4'(m_score / 10), 4'(m_score % 10),
            4'(m_hi / 10), 4'(m_hi % 10), m_nr};
  endfunction

  task automatic model_reset();
    m_state = 0; m_sub = 0; m_score = 0; m_hi = 0; m_nr = 1'b0;
  endtask

  // Drive one cycle of stimulus, predict the outcome, compare after the edge.
  task automatic step(input bit p, input bit t);
    logic [18:0] e;
    playing = p;
    frame_tick = t;
    m_nr = 1'b0;
    case (m_state)
      0, 2: if (p) begin m_state = 1; m_sub = 0; m_score = 0; end
      1: begin
        if (!p) begin
          m_state = 2;
          if (HI_EN && m_score > m_hi) begin m_hi = m_score; m_nr = 1'b1; end
        end else if (t) begin
          if (m_sub == UD - 1) begin
            m_sub = 0;
            if (m_score < 99) m_score++;
          end else m_sub++;
        end
      end
      default: m_state = 0;
    endcase
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_val("cycle", 32'(dut_vec), 32'(e));
    end
    frame_tick = 1'b0;
  endtask

  // Counted ticks with occasional idle gaps; back-to-back ticks model a
  // frame_tick held high for several cycles.
  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_state"}, 32'(state_o), 32'd0);
    check_val({tag, "_score"}, 32'({score_tens, score_ones}), 32'h00);
    check_val({tag, "_hi"}, 32'({hi_tens, hi_ones}), 32'h00);
    check_val({tag, "_nr"}, 32'(new_record), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    playing = 1'b0;
    frame_tick = 1'b0;
    #1;
    check_all_zero("rst");
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("por");
    rst_n = 1'b1;
    step(1'b0, 1'b1);               // tick ignored in IDLE
    check_all_zero("idle_tick");

    // 29 ticks -> 00, 30th -> 01
    step(1'b1, 1'b0);
    check_val("run_state", 32'(state_o), 32'd1);
    run_ticks(29);
    check_val("t29", 32'({score_tens, score_ones}), 32'h00);
    run_ticks(1);
    check_val("t30", 32'({score_tens, score_ones}), 32'h01);

    // up to 99, then saturation
    run_ticks(2940);
    check_val("t2970", 32'({score_tens, score_ones}), 32'h99);
    run_ticks(300);
    check_val("sat99", 32'({score_tens, score_ones}), 32'h99);

    // BCD carry 09 -> 10
    do_reset();
    step(1'b1, 1'b0);
    run_ticks(270);
    check_val("bcd09", 32'({score_tens, score_ones}), 32'h09);
    run_ticks(30);
    check_val("bcd10", 32'({score_tens, score_ones}), 32'h10);

    // high score: 12 (record), 12 (tie), 15 (record)
    do_reset();
    step(1'b1, 1'b0);
    run_ticks(360);
    step(1'b0, 1'b0);
    check_val("hs1_state", 32'(state_o), 32'd2);
    check_val("hs1_hi", 32'({hi_tens, hi_ones}), HI_EN ? 32'h12 : 32'h00);
    check_val("hs1_nr", 32'(new_record), 32'(HI_EN));
    step(1'b0, 1'b0);
    check_val("hs1_nr_once", 32'(new_record), 32'd0);
    step(1'b1, 1'b0);
    run_ticks(360);
    step(1'b0, 1'b0);
    check_val("hs2_hi", 32'({hi_tens, hi_ones}), HI_EN ? 32'h12 : 32'h00);
    check_val("hs2_nr", 32'(new_record), 32'd0);
    step(1'b1, 1'b0);
    run_ticks(450);
    step(1'b0, 1'b0);
    check_val("hs3_hi", 32'({hi_tens, hi_ones}), HI_EN ? 32'h15 : 32'h00);
    check_val("hs3_nr", 32'(new_record), 32'(HI_EN));
    check_val("hs3_score", 32'({score_tens, score_ones}), 32'h15);

    // tick in the cycle playing falls at sub-counter 29 is discarded
    step(1'b1, 1'b0);
    run_ticks(29);
    step(1'b0, 1'b1);
    check_val("drop_score", 32'({score_tens, score_ones}), 32'h00);
    check_val("drop_state", 32'(state_o), 32'd2);
    step(1'b1, 1'b0);
    check_val("restart_state", 32'(state_o), 32'd1);
    check_val("restart_score", 32'({score_tens, score_ones}), 32'h00);
    run_ticks(29);
    check_val("restart_t29", 32'({score_tens, score_ones}), 32'h00);
    run_ticks(1);
    check_val("restart_t30", 32'({score_tens, score_ones}), 32'h01);

    // async reset mid-run at score 42 with high score 50
    do_reset();
    step(1'b1, 1'b0);
    run_ticks(1500);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    run_ticks(1260);
    check_val("pre_rst_score", 32'({score_tens, score_ones}), 32'h42);
    check_val("pre_rst_hi", 32'({hi_tens, hi_ones}), HI_EN ? 32'h50 : 32'h00);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    playing = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    check_all_zero("post_rst_idle");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
